// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter and transaction sequencer in front of a shared SPI byte engine.
// Define SPI_TIMEOUT_EN to add an eng_done watchdog that aborts a stuck transaction.
module spi_txn_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int LEN_W       = 4,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int CS_GAP      = 4,
  parameter int TIMEOUT_CYC = 64,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_rw,
  input  logic [NUM_REQ*8-1:0]     req_addr,
  input  logic [NUM_REQ*8-1:0]     req_wdata,
  input  logic [NUM_REQ*LEN_W-1:0] req_rlen,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy,
  output logic                     eng_start,
  output logic [7:0]               eng_tx,
  input  logic                     eng_done,
  input  logic [7:0]               eng_rx,
  output logic                     cs_n,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  output logic [IW-1:0]            rd_id,
  output logic                     rd_last,
  output logic                     txn_done,
  output logic                     err
);

  localparam int KW   = LEN_W + 1;
  localparam int CM0  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CMAX = (CM0 > CS_GAP) ? CM0 : CS_GAP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT, HOLD, GAP} state_t;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win;
  logic [CW-1:0]    cnt;
  logic [KW-1:0]    k;
  logic [KW-1:0]    k_last;
  logic             rw_q;
  logic [7:0]       addr_q;
  logic [7:0]       wdata_q;
  logic [LEN_W-1:0] rlen_w;
  logic [KW-1:0]    last_w;

  // Lowest offset from the pointer wins, so scan from the far end down.
  function automatic logic [IW-1:0] rr_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [IW-1:0]      p
  );
    logic [IW-1:0] w;
    int            j;
    w = p;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(p) + i) % NUM_REQ;
      if (r[j]) w = IW'(j);
    end
    return w;
  endfunction

  function automatic logic [7:0] tx_byte(
    input logic [KW-1:0] n,
    input logic          rw,
    input logic [7:0]    a,
    input logic [7:0]    d
  );
    logic [7:0] b;
    unique case (1'b1)
      (n == KW'(0)): b = rw ? 8'h0B : 8'h0A;
      (n == KW'(1)): b = a;
      default:       b = rw ? 8'h00 : d;
    endcase
    return b;
  endfunction

  assign win    = rr_pick(req, ptr);
  assign rlen_w = req_rlen[LEN_W*int'(win) +: LEN_W];
  assign last_w = req_rw[win]
                ? KW'((rlen_w == '0) ? LEN_W'(1) : rlen_w) + KW'(1)
                : KW'(2);

`ifdef SPI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd;
  logic          err_q;
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      k         <= '0;
      k_last    <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ack       <= '0;
      busy      <= 1'b0;
      eng_start <= 1'b0;
      eng_tx    <= '0;
      cs_n      <= 1'b1;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_id     <= '0;
      rd_last   <= 1'b0;
      txn_done  <= 1'b0;
`ifdef SPI_TIMEOUT_EN
      wd        <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      ack       <= '0;
      eng_start <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      txn_done  <= 1'b0;
`ifdef SPI_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      unique case (state)
        IDLE: if (|req) begin
          rw_q    <= req_rw[win];
          addr_q  <= req_addr[8*int'(win) +: 8];
          wdata_q <= req_wdata[8*int'(win) +: 8];
          k_last  <= last_w;
          k       <= '0;
          cnt     <= '0;
          ack     <= NUM_REQ'(1) << win;
          busy    <= 1'b1;
          cs_n    <= 1'b0;
          rd_id   <= win;
          ptr     <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
          state   <= SETUP;
        end
        SETUP: if (cnt == CW'(CS_SETUP - 1)) begin
          eng_start <= 1'b1;
          eng_tx    <= tx_byte(k, rw_q, addr_q, wdata_q);
          state     <= SEND;
        end else begin
          cnt <= cnt + 1'b1;
        end
        SEND: begin
          state <= WAIT;
`ifdef SPI_TIMEOUT_EN
          wd    <= '0;
`endif
        end
        WAIT: if (eng_done) begin
          if (rw_q && k >= KW'(2)) begin
            rd_valid <= 1'b1;
            rd_data  <= eng_rx;
            rd_last  <= (k == k_last);
          end
          // The done cycle counts as the first hold cycle.
          if (k == k_last) begin
            cnt   <= CW'(1);
            state <= HOLD;
          end else begin
            k         <= k + 1'b1;
            eng_start <= 1'b1;
            eng_tx    <= tx_byte(k + 1'b1, rw_q, addr_q, wdata_q);
            state     <= SEND;
          end
        end
`ifdef SPI_TIMEOUT_EN
        else if (wd == TW'(TIMEOUT_CYC - 1)) begin
          err_q <= 1'b1;
          cs_n  <= 1'b1;
          cnt   <= '0;
          state <= GAP;
        end else begin
          wd <= wd + 1'b1;
        end
`endif
        HOLD: if (cnt >= CW'(CS_HOLD - 1)) begin
          cs_n     <= 1'b1;
          txn_done <= 1'b1;
          cnt      <= '0;
          state    <= GAP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        GAP: if (cnt == CW'(CS_GAP - 1)) begin
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed table-driven bench for spi_txn_arbiter with a behavioural byte engine.
module tb_spi_txn_arbiter;

  localparam int NR  = 2;
  localparam int LW  = 4;
  localparam int CSS = 2;
  localparam int CSH = 2;
  localparam int CSG = 4;
  localparam int TO  = 64;
  localparam int LAT = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR-1:0]    req_rw = '0;
  logic [NR*8-1:0]  req_addr = '0;
  logic [NR*8-1:0]  req_wdata = '0;
  logic [NR*LW-1:0] req_rlen = '0;
  logic [NR-1:0]    ack;
  logic             busy;
  logic             eng_start;
  logic [7:0]       eng_tx;
  logic             eng_done = 1'b0;
  logic [7:0]       eng_rx = '0;
  logic             cs_n;
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic [0:0]       rd_id;
  logic             rd_last;
  logic             txn_done;
  logic             err;

  spi_txn_arbiter #(
    .NUM_REQ(NR), .LEN_W(LW), .CS_SETUP(CSS),
    .CS_HOLD(CSH), .CS_GAP(CSG), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rlen(req_rlen),
    .ack(ack), .busy(busy), .eng_start(eng_start), .eng_tx(eng_tx),
    .eng_done(eng_done), .eng_rx(eng_rx), .cs_n(cs_n),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id),
    .rd_last(rd_last), .txn_done(txn_done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] txq[$];
  logic [7:0] rdq[$];
  logic       rdidq[$];
  logic       rdlq[$];
  int         ackq[$];
  int tdone_cnt = 0, tdone_id = 0, err_cnt = 0, err_cyc = 0;
  int two_ack = 0, bad_rd_tm = 0, bad_st_tm = 0, min_gap = 1000;
  int fall_cyc = 0, rise_cyc = 0, st_cyc = 0, last_done_cyc = 0;
  int setup_d = 0, hold_d = 0, eng_k = 0, eng_cnt = 0, st_in_txn = 0;
  bit have_rise = 0, eng_en = 1;
  logic err_cs = 1'b0;
  logic prev_cs = 1'b1;
  logic [7:0] rx0 = '0, step = '0;

  // Engine model plus event logger, all sampled mid-cycle.
  always @(negedge clk) begin
    eng_done = 1'b0;
    if (prev_cs && !cs_n) begin
      fall_cyc = cyc; st_in_txn = 0; eng_k = 0;
      if (have_rise && (cyc - rise_cyc) < min_gap) min_gap = cyc - rise_cyc;
    end
    if (!prev_cs && cs_n) begin
      rise_cyc = cyc; have_rise = 1; hold_d = cyc - last_done_cyc;
    end
    prev_cs = cs_n;
    if (rd_valid) begin
      rdq.push_back(rd_data); rdidq.push_back(rd_id[0]); rdlq.push_back(rd_last);
      if (cyc != last_done_cyc + 1) bad_rd_tm++;
    end
    if ($countones(ack) > 1) two_ack++;
    for (int i = 0; i < NR; i++) if (ack[i]) ackq.push_back(i);
    if (txn_done) begin tdone_cnt++; tdone_id = int'(rd_id); end
    if (err) begin err_cnt++; err_cyc = cyc; err_cs = cs_n; end
    if (rst) begin
      eng_cnt = 0;
    end else if (eng_start) begin
      txq.push_back(eng_tx);
      if (st_in_txn == 0) begin setup_d = cyc - fall_cyc; st_cyc = cyc; end
      else if (cyc != last_done_cyc + 1) bad_st_tm++;
      st_in_txn++;
      if (eng_en) eng_cnt = LAT;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done = 1'b1;
        eng_rx = (eng_k < 2) ? 8'hFF : 8'(rx0 + step * (eng_k - 2));
        eng_k++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clr();
    txq.delete(); rdq.delete(); rdidq.delete(); rdlq.delete(); ackq.delete();
    tdone_cnt = 0; bad_rd_tm = 0; bad_st_tm = 0; two_ack = 0;
    min_gap = 1000; have_rise = 0;
  endtask

  task automatic issue(input int id, input logic rw, input logic [7:0] a,
                       input logic [7:0] wd, input logic [3:0] rl);
    req_rw[id] = rw;
    req_addr[8*id +: 8] = a;
    req_wdata[8*id +: 8] = wd;
    req_rlen[LW*id +: LW] = rl;
    req[id] = 1'b1;
  endtask

  task automatic wait_ack(input int id, output int lat);
    lat = 0;
    do begin tick(1); lat++; end while (!ack[id] && lat < 60);
    req[id] = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (tdone_cnt < n && t < 600) begin tick(1); t++; end
  endtask

  typedef struct {
    int id; logic rw; logic [7:0] addr; logic [7:0] wdata; logic [3:0] rlen;
    logic [7:0] rx0; logic [7:0] step; logic [7:0] b0; logic [7:0] b2;
    int nst; int nrd; logic [7:0] d_first; logic [7:0] d_last;
  } vec_t;

  vec_t tab[5];

  initial begin
    int lat, mism, badid, nlast, t, e0;
    logic [7:0] e;
    tab[0] = '{0, 1'b0, 8'h2D, 8'h02, 4'd0,  8'h00, 8'h00, 8'h0A, 8'h02, 3,  0,  8'h00, 8'h00};
    tab[1] = '{1, 1'b1, 8'h08, 8'h00, 4'd2,  8'h12, 8'h22, 8'h0B, 8'h00, 4,  2,  8'h12, 8'h34};
    tab[2] = '{0, 1'b1, 8'h0E, 8'hA5, 4'd0,  8'h55, 8'h01, 8'h0B, 8'h00, 3,  1,  8'h55, 8'h55};
    tab[3] = '{1, 1'b1, 8'h10, 8'h00, 4'd15, 8'h01, 8'h01, 8'h0B, 8'h00, 17, 15, 8'h01, 8'h0F};
    tab[4] = '{1, 1'b0, 8'h1F, 8'h52, 4'd7,  8'h00, 8'h00, 8'h0A, 8'h52, 3,  0,  8'h00, 8'h00};

    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_tx", eng_tx, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_id", rd_id, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_txn_done", txn_done, 0);
    chk("rst_err", err, 0);

    for (int v = 0; v < 5; v++) begin
      clr();
      rx0 = tab[v].rx0;
      step = tab[v].step;
      issue(tab[v].id, tab[v].rw, tab[v].addr, tab[v].wdata, tab[v].rlen);
      wait_ack(tab[v].id, lat);
      chk($sformatf("v%0d_ack_lat", v), lat, 1);
      chk($sformatf("v%0d_cs_at_ack", v), cs_n, 0);
      chk($sformatf("v%0d_busy_at_ack", v), busy, 1);
      wait_done(1);
      chk($sformatf("v%0d_txn_done", v), tdone_cnt, 1);
      chk($sformatf("v%0d_done_id", v), tdone_id, tab[v].id);
      tick(CSG + 3);
      chk($sformatf("v%0d_n_start", v), txq.size(), tab[v].nst);
      mism = 0;
      foreach (txq[j]) begin
        e = (j == 0) ? tab[v].b0 : (j == 1) ? tab[v].addr : tab[v].b2;
        if (txq[j] !== e) mism++;
      end
      chk($sformatf("v%0d_tx_bytes", v), mism, 0);
      chk($sformatf("v%0d_n_rd", v), rdq.size(), tab[v].nrd);
      chk($sformatf("v%0d_rd_first", v), (rdq.size() > 0) ? rdq[0] : 8'h00, tab[v].d_first);
      chk($sformatf("v%0d_rd_lastdata", v), (rdq.size() > 0) ? rdq[$] : 8'h00, tab[v].d_last);
      badid = 0;
      nlast = 0;
      foreach (rdidq[j]) if (int'(rdidq[j]) != tab[v].id) badid++;
      foreach (rdlq[j]) nlast += int'(rdlq[j]);
      chk($sformatf("v%0d_rd_id", v), badid, 0);
      chk($sformatf("v%0d_rd_last_cnt", v), nlast, (tab[v].nrd > 0) ? 1 : 0);
      chk($sformatf("v%0d_rd_last_pos", v), (rdlq.size() > 0) ? rdlq[$] : 1'b0,
          (tab[v].nrd > 0) ? 1 : 0);
      chk($sformatf("v%0d_rd_timing", v), bad_rd_tm, 0);
      chk($sformatf("v%0d_start_timing", v), bad_st_tm, 0);
      chk($sformatf("v%0d_setup", v), setup_d, CSS);
      chk($sformatf("v%0d_hold", v), hold_d, CSH);
      chk($sformatf("v%0d_busy_idle", v), busy, 0);
      chk($sformatf("v%0d_cs_idle", v), cs_n, 1);
    end

    // Both requesters held from reset: grants must alternate.
    rst = 1'b1;
    clr();
    issue(0, 1'b0, 8'h2D, 8'h02, 4'd0);
    issue(1, 1'b0, 8'h31, 8'h44, 4'd0);
    tick(2);
    rst = 1'b0;
    t = 0;
    while (ackq.size() < 4 && t < 500) begin tick(1); t++; end
    req = '0;
    tick(40);
    chk("rr_ack_count", ackq.size(), 4);
    mism = 0;
    foreach (ackq[j]) if (ackq[j] != (j % 2)) mism++;
    chk("rr_order", mism, 0);
    chk("rr_two_ack", two_ack, 0);
    chk("rr_gap", (min_gap >= CSG && min_gap < 1000) ? 1 : 0, 1);
    chk("rr_done_cnt", tdone_cnt, 4);

    // Reset in the middle of the second byte's wait.
    clr();
    rx0 = 8'h12;
    step = 8'h22;
    issue(0, 1'b1, 8'h08, 8'h00, 4'd2);
    wait_ack(0, lat);
    t = 0;
    while (txq.size() < 2 && t < 100) begin tick(1); t++; end
    chk("mid_second_start", txq.size(), 2);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_cs_n", cs_n, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_txn_done", txn_done, 0);
    rst = 1'b0;
    tick(6);
    chk("mid_no_rd", rdq.size(), 0);
    chk("mid_no_done", tdone_cnt, 0);

    // Pointer back at 0: requester 0 beats requester 1.
    clr();
    issue(0, 1'b0, 8'h2D, 8'h02, 4'd0);
    issue(1, 1'b0, 8'h33, 8'h44, 4'd0);
    t = 0;
    do begin tick(1); t++; end while (ack == '0 && t < 20);
    chk("ptr_reset_ack", ack, 2'b01);
    req = '0;
    wait_done(1);
    chk("ptr_done_id", tdone_id, 0);
    tick(CSG + 8);
    mism = 0;
    foreach (txq[j]) begin
      e = (j == 0) ? 8'h0A : (j == 1) ? 8'h2D : 8'h02;
      if (txq[j] !== e) mism++;
    end
    chk("ptr_tx_n", txq.size(), 3);
    chk("ptr_tx_bytes", mism, 0);
    chk("ptr_dropped_req", ackq.size(), 1);

`ifdef SPI_TIMEOUT_EN
    clr();
    eng_en = 0;
    e0 = err_cnt;
    issue(0, 1'b0, 8'h2D, 8'h02, 4'd0);
    wait_ack(0, lat);
    t = 0;
    while (err_cnt == e0 && t < 200) begin tick(1); t++; end
    chk("to_err_seen", err_cnt, e0 + 1);
    chk("to_err_lat", err_cyc - st_cyc, TO + 1);
    chk("to_err_cs", err_cs, 1);
    tick(2);
    chk("to_no_done", tdone_cnt, 0);
    eng_en = 1;
    tick(8);
    issue(1, 1'b0, 8'h20, 8'h11, 4'd0);
    wait_ack(1, lat);
    wait_done(1);
    chk("to_next_done", tdone_cnt, 1);
    chk("to_next_id", tdone_id, 1);
`else
    e0 = 0;
    chk("err_never", err_cnt, e0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench stalled");
  end

endmodule
